gpio_cmd_decoder: RTL
=====================

// Module: gpio_cmd_decoder
// PURPOSE
// - Front end of the config path. Takes the raw 32-bit PS GPIO word: bit 24 = write clock, [23:16] = data, [15:0] = register address.
// - Resynchronises the word to the fabric clock and turns each rising edge of the write clock into one {addr,data} command.
// - Buffers commands in a small FIFO and presents them on a valid/ready port to the config register bank, which decodes run_trig, halt, the scaler and shift registers, and so on.
// PARAMETERS
// GPIO_W        32  width of the GPIO input word
// W_CLK_BIT     24  bit index of the software write clock
// ADDR_LSB      0   LSB of the address field
// ADDR_W        16  address field width
// DATA_LSB      16  LSB of the data field
// DATA_W        8   data field width
// FIFO_AW       2   log2 of the command FIFO depth (default depth 4)
// PORTS
// clk           in   1        fabric clock; the block's only clock
// rst           in   1        asynchronous, active-low reset
// gpio_in       in   GPIO_W   raw PS GPIO word, asynchronous to clk
// cmd_valid     out  1        FIFO head holds a command
// cmd_ready     in   1        consumer accepts the head this cycle
// cmd_addr      out  ADDR_W   address at the FIFO head
// cmd_data      out  DATA_W   data at the FIFO head
// overflow      out  1        sticky: a command was dropped because the FIFO was full
// overflow_clr  in   1        synchronous clear of overflow
// wr_count      out  16       count of accepted commands, wraps 0xFFFF->0x0000
// BEHAVIOUR
// - Reset (rst=0, async): sync regs, FIFO pointers, overflow, wr_count and the arm flag all go to 0.
//   cmd_valid=0; cmd_addr/cmd_data=0.
// - Synchroniser: every gpio_in bit passes through s1->s2, two flops.
//   A third flop s3 holds the previous s2 value of W_CLK_BIT only.
// - Arm: set the first cycle s2[W_CLK_BIT]==0 after reset.
//   No edge is recognised while the arm flag is 0, so a write clock held high through reset causes no spurious write.
// - Edge: edge = arm & s2[W_CLK_BIT] & ~s3.
//   On edge, push {s2[ADDR field], s2[DATA field]}. A falling edge does nothing.
// - Software contract: addr/data are stable at least 3 clk before the write clock rises, and it stays high at least 3 clk.
// - Latency: write-clock pin rise -> cmd_valid=1 at the 3rd rising clk edge after the pin changes, when the FIFO was empty.
// - FIFO: depth 2**FIFO_AW, show-ahead.
//   cmd_valid = ~empty; cmd_addr/cmd_data come straight from the head entry.
//   Pop on cmd_valid & cmd_ready.
//   cmd_addr/cmd_data hold their value while cmd_valid=1 and cmd_ready=0.
// - Push when full with no pop in the same cycle: command dropped, overflow<=1, wr_count unchanged.
// - Push and pop in the same cycle while full: both take effect, no overflow.
// - Push and pop in the same cycle while empty: the push is stored; cmd_valid rises next cycle.
// - wr_count increments by 1 on each accepted push.
// - overflow_clr and a new overflow event in the same cycle: overflow stays 1 (set wins).
// - Reset asserted mid-operation: everything returns to its reset value.
//   Queued commands are lost, and the arm flag must be re-acquired.
// TESTING
// - Edge case: reset with gpio_in[24]=1, then release reset -> no cmd_valid.
//   Then drop bit 24 low and raise it again with addr=0x0002, data=0x01 -> exactly one command 0x0002/0x01.
// - Latency: FIFO empty, cmd_ready=1, write addr=0x000C data=0xA5 -> cmd_valid=1 on the 3rd clk edge after bit 24 rises.
//   cmd_valid is high for 1 cycle, wr_count=1.
// - Backpressure: cmd_ready=0, write 4 commands (0x15/0x10 .. 0x15/0x13) -> all retained, overflow=0.
//   A 5th write -> overflow=1, wr_count=4.
//   Then cmd_ready=1 -> data 0x10, 0x11, 0x12, 0x13 come out in order.
// - Full with simultaneous pop: FIFO full, cmd_ready=1 in the same cycle a push arrives -> no overflow, wr_count increments.
// - Overflow clear: pulse overflow_clr with no push -> overflow=0.
//   Pulse overflow_clr in the same cycle as a dropped push -> overflow stays 1.
// - Mid-run reset: 2 commands queued, assert rst -> cmd_valid=0, wr_count=0 on the next sample, and no command reappears after release.

Source files
------------

// File: rtl/gpio_cmd_decoder.sv
// gpio_cmd_decoder
// Front end of the config path. Resynchronises the raw PS GPIO word to the
// fabric clock, turns each rising edge of the software write clock into one
// {addr,data} command, and queues commands in a small show-ahead FIFO that
// feeds the config register bank over a valid/ready port.

module gpio_cmd_decoder #(
  parameter int GPIO_W    = 32,
  parameter int W_CLK_BIT = 24,
  parameter int ADDR_LSB  = 0,
  parameter int ADDR_W    = 16,
  parameter int DATA_LSB  = 16,
  parameter int DATA_W    = 8,
  parameter int FIFO_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef logic [FIFO_AW:0] ptr_t;
  localparam ptr_t        PTR_INC   = ptr_t'(1);
  localparam logic [15:0] COUNT_INC = 16'd1;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [GPIO_W-1:0] s1;
  logic [GPIO_W-1:0] s2;
  logic              s3;
  // fill[1] is set once s2 holds a real sample of gpio_in rather than its
  // reset value; until then the arm logic must not look at s2.
  logic [1:0]        fill;
  logic              arm;

  // Two-flop resync of the whole word, plus a history flop for the write clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= 1'b0;
      fill <= '0;
    end else begin
      // NOTE: non-blocking assignments make s1->s2->s3 a real shift chain;
      // blocking ones would collapse it into a single flop.
      s1   <= gpio_in;
      s2   <= s1;
      s3   <= s2[W_CLK_BIT];
      fill <= {fill[0], 1'b1};
    end
  end

  // Arm once a genuine low level of the write clock has been seen, so a
  // write clock held high through reset never produces a spurious command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm <= 1'b0;
    end else if (fill[1] && !s2[W_CLK_BIT]) begin
      arm <= 1'b1;
    end
  end

  logic wclk_rise;
  cmd_t push_cmd;

  assign wclk_rise     = arm & s2[W_CLK_BIT] & ~s3;
  assign push_cmd.addr = s2[ADDR_LSB +: ADDR_W];
  assign push_cmd.data = s2[DATA_LSB +: DATA_W];

  // Bits of the word outside the write clock, address and data fields are
  // carried through the synchroniser but not otherwise used.
  logic unused_gpio_bits;
  assign unused_gpio_bits = ^s2;

  // ---------------------------------------------------------------------------
  // Command FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  cmd_t mem [DEPTH];
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  logic empty;
  logic full;
  logic pop;
  logic push_ok;
  logic push_drop;
  cmd_t head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign pop       = cmd_valid & cmd_ready;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // still lands.
  assign push_ok   = wclk_rise & (~full | pop);
  assign push_drop = wclk_rise & full & ~pop;

  // Storage write.
  // NOTE: the storage array has no reset; stale entries are never visible
  // because the outputs are gated by cmd_valid below, and leaving it
  // unreset lets it map onto plain registers or distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= push_cmd;
    end
  end

  // Read and write pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_INC;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_INC;
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Count of accepted commands, free-running and wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (push_ok) begin
      wr_count <= wr_count + COUNT_INC;
    end
  end

  // ---------------------------------------------------------------------------
  // Output port
  // ---------------------------------------------------------------------------
  assign head = mem[rd_ptr[FIFO_AW-1:0]];

  // Present the head entry; drive zeros whenever the FIFO is empty.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    cmd_valid = ~empty;
    cmd_addr  = '0;
    cmd_data  = '0;
    if (!empty) begin
      cmd_addr = head.addr;
      cmd_data = head.data;
    end
  end

endmodule
